// File: rtl/vga_scan_timer.sv
// rtl/vga_scan_timer.sv - raster scan timer: address generation, sync/blank delay line, RGB output stage
module vga_scan_timer #(
    parameter int H_SYNC   = 120,
    parameter int H_BACK   = 64,
    parameter int H_ACTIVE = 800,
    parameter int H_FRONT  = 56,
    parameter int V_SYNC   = 6,
    parameter int V_BACK   = 23,
    parameter int V_ACTIVE = 600,
    parameter int V_FRONT  = 37,
    parameter bit SYNC_POL = 1'b1,
    parameter int PIPE_LAT = 0
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        pix_en,
    output logic [21:0] display_addr,
    input  logic [2:0]  display_data,
    output logic        hsync,
    output logic        vsync,
    output logic        vga_r,
    output logic        vga_g,
    output logic        vga_b,
    output logic        video_on,
    output logic        frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    // Wrap points fit in 11 bits as long as each total is at most 2048.
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    // Region bounds are compared at 12 bits so an end bound of exactly 2048 still works.
    localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
    localparam logic [11:0] H_ACT_BEG  = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] H_ACT_END  = 12'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [11:0] V_SYNC_END = 12'(V_SYNC);
    localparam logic [11:0] V_ACT_BEG  = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] V_ACT_END  = 12'(V_SYNC + V_BACK + V_ACTIVE);

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic fs;
    } decode_t;

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    decode_t     dec;
    decode_t     dec_d;

    // Horizontal/vertical scan counters; the line counter steps only on the pixel wrap.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    // The counters are the address register, so the address is the raw scan position.
    assign display_addr = {h_cnt, v_cnt};

    // Stage-0 decode of the address currently presented to the pixel source.
    always_comb begin
        dec     = '0;
        dec.hs  = ({1'b0, h_cnt} < H_SYNC_END);
        dec.vs  = ({1'b0, v_cnt} < V_SYNC_END);
        dec.act = ({1'b0, h_cnt} >= H_ACT_BEG) && ({1'b0, h_cnt} < H_ACT_END) &&
                  ({1'b0, v_cnt} >= V_ACT_BEG) && ({1'b0, v_cnt} < V_ACT_END);
        dec.fs  = (h_cnt == 11'd0) && (v_cnt == 11'd0);
    end

    // Delay line matching the pixel source's extra latency; absent when the source is combinational.
    generate
        if (PIPE_LAT == 0) begin : g_no_dly
            assign dec_d = dec;
        end else begin : g_dly
            decode_t dly_q [PIPE_LAT];

            // Shift the decode along with each pixel step; reset flushes to idle.
            always_ff @(posedge sysclk) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        dly_q[i] <= '0;
                    end
                end else if (pix_en) begin
                    dly_q[0] <= dec;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign dec_d = dly_q[PIPE_LAT-1];
        end
    endgenerate

    // Output stage: sample the pixel together with its aligned decode and blank outside the active area.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            vga_r       <= 1'b0;
            vga_g       <= 1'b0;
            vga_b       <= 1'b0;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            hsync                 <= dec_d.hs ? SYNC_POL : ~SYNC_POL;
            vsync                 <= dec_d.vs ? SYNC_POL : ~SYNC_POL;
            {vga_r, vga_g, vga_b} <= dec_d.act ? display_data : 3'b000;
            video_on              <= dec_d.act;
            frame_start           <= dec_d.fs;
        end else begin
            // A stalled step must not stretch the frame marker.
            frame_start <= 1'b0;
        end
    end

endmodule

// File: doc/vga_scan_timer.md
Name: vga_scan_timer

Overview:
- Raster scan initiator on the display side of the pixel interface.
- Generates horizontal/vertical counters and presents `display_addr = {x[10:0], y[10:0]}` to the pixel source (f2_gpu class consumers).
- Samples the returned 3-bit `display_data` and drives VGA hsync, vsync and RGB, with sync and blanking delayed to align with the pixel path latency.
- Default timing: 800x600@72Hz on a 50 MHz pixel rate.

Parameters:
- H_SYNC, 120, hsync pulse width in pixels
- H_BACK, 64, horizontal back porch
- H_ACTIVE, 800, horizontal visible pixels
- H_FRONT, 56, horizontal front porch
- V_SYNC, 6, vsync pulse width in lines
- V_BACK, 23, vertical back porch
- V_ACTIVE, 600, vertical visible lines
- V_FRONT, 37, vertical front porch
- SYNC_POL, 1, asserted level of hsync/vsync (1 = active-high)
- PIPE_LAT, 0, extra `pix_en` steps between `display_addr` and valid `display_data` (legal range 0..3)

Ports:
- sysclk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- pix_en  in  1  pixel-rate enable; the pipeline advances only when high
- display_addr  out  22  {h_cnt[10:0], v_cnt[10:0]}, raw counter values including sync and porch
- display_data  in  3  pixel from source, {R,G,B}
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- vga_r  out  1  red
- vga_g  out  1  green
- vga_b  out  1  blue
- video_on  out  1  high when current RGB output is in the visible region
- frame_start  out  1  one-sysclk pulse when the aligned output reaches h=0, v=0

Behaviour:
- Definitions: H_TOTAL = sum of the four H params; V_TOTAL likewise. Counter order within a line/frame: sync, back porch, active, front porch.
- Reset (rst_n = 0 at a sysclk edge; pix_en ignored):
  - h_cnt = v_cnt = 0, `display_addr` = 0.
  - hsync = vsync = ~SYNC_POL; vga_r/g/b = 0; video_on = 0; frame_start = 0.
  - All delay-stage contents cleared to these idle values.
- Counters, on a sysclk edge with pix_en = 1:
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments only on the h wrap and wraps V_TOTAL-1 -> 0.
  - pix_en = 0: every register holds, including all delay stages. frame_start is forced to 0 on any cycle it is not newly generated, so it never lasts more than one sysclk.
- Address stage: `display_addr` is registered and equals the counters' values after each advance. Width is always 11+11 bits; upper bits are zero-padded.
- Stage-0 decode per (h,v):
  - hs = (h < H_SYNC); vs = (v < V_SYNC).
  - act = (H_SYNC+H_BACK <= h < H_SYNC+H_BACK+H_ACTIVE) and (V_SYNC+V_BACK <= v < V_SYNC+V_BACK+V_ACTIVE).
  - fs = (h==0 && v==0).
- Delay line: hs/vs/act/fs pass through PIPE_LAT pix_en-qualified stages, registered alongside `display_addr`.
- Output stage, on pix_en:
  - `display_data` is sampled on the same step that the delayed decode reaches output.
  - hsync = hs_d ? SYNC_POL : ~SYNC_POL; vsync likewise.
  - {vga_r,vga_g,vga_b} = act_d ? display_data : 3'b000; video_on = act_d; frame_start = fs_d.
- Latency: outputs correspond to the address presented PIPE_LAT+1 pix_en steps earlier. With pix_en tied high and PIPE_LAT = 0, RGB for a given address appears one sysclk after that address.
- Blanking is enforced here regardless of `display_data`. A non-zero source value during porch or sync must never reach the RGB pins.
- Reset mid-frame: the next cycle restarts at h=0, v=0 with idle outputs. Outputs go through no partial line sequence.
- Parameter sanity: H_TOTAL and V_TOTAL must each be <= 2048. The counter uses exactly 11 bits, with no overflow beyond the wrap compare.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with display_data = 3'b111 -> display_addr = 0, hsync = vsync = 0 (SYNC_POL = 1), RGB = 0, video_on = 0, frame_start = 0.
- Line timing (defaults, pix_en = 1, PIPE_LAT = 0):
  - hsync high for exactly 120 consecutive cycles per 1040-cycle period.
  - display_addr[21:11] runs 0..1039 and wraps.
  - display_addr[10:0] increments on each wrap, 0..665 then 0.
- Frame timing: vsync high for exactly 6×1040 cycles per 666×1040-cycle frame; frame_start pulses once per frame, 1 cycle wide.
- Alignment (PIPE_LAT = 2): drive display_data = display_addr[13:11] delayed by 2 cycles. RGB must equal x[2:0] of the address 3 cycles earlier inside the active region, and 000 outside it; video_on first rises 3 cycles after address x=184, y=29.
- pix_en stall: pix_en toggling 1,0,1,0 -> display_addr advances every other sysclk, line period = 2080 sysclk, and all outputs hold during low cycles. frame_start is still a single sysclk.
- Mid-frame reset: pulse rst_n low at x=500, y=300 -> the next cycle has display_addr = 0 and idle outputs, and normal timing resumes from 0.
